// File: rtl/svga_playfield_renderer.sv
// Purpose : renders a double-buffered 10x20 tile map into the SVGA Tetris playfield and
//           forwards HS/VS/blank aligned with the colour (define GRID_LINES_EN for a 1-pixel tile grid).
// Latency : 2 cycles from row/col/sync/blank in to rgb/sync/blank out; writes and swaps never stall.
// Ports   : clk/reset_n; row_in/col_in/hs_in/vs_in/blank_in from the timing generator;
//           wr_en/wr_x/wr_y/wr_color back-buffer write; swap_req -> swap_pend/swap_done;
//           wr_err flags a dropped write; rgb_out/hs_out/vs_out/blank_out to the DAC.
module svga_playfield_renderer #(
    parameter int ORIGIN_ROW = 50,
    parameter int ORIGIN_COL = 300,
    parameter int TILE_H     = 25,
    parameter int TILE_W     = 20,
    parameter int PF_ROWS    = 20,
    parameter int PF_COLS    = 10,
    parameter int BORDER     = 4,
    parameter int V_VISIBLE  = 600
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [9:0]  row_in,
    input  logic [9:0]  col_in,
    input  logic        hs_in,
    input  logic        vs_in,
    input  logic        blank_in,
    input  logic        wr_en,
    input  logic [3:0]  wr_x,
    input  logic [4:0]  wr_y,
    input  logic [2:0]  wr_color,
    input  logic        swap_req,
    output logic        swap_pend,
    output logic        swap_done,
    output logic        wr_err,
    output logic [23:0] rgb_out,
    output logic        hs_out,
    output logic        vs_out,
    output logic        blank_out
);

    localparam logic [9:0] FIELD_R0  = 10'(ORIGIN_ROW);
    localparam logic [9:0] FIELD_R1  = 10'(ORIGIN_ROW + TILE_H * PF_ROWS);
    localparam logic [9:0] FIELD_C0  = 10'(ORIGIN_COL);
    localparam logic [9:0] FIELD_C1  = 10'(ORIGIN_COL + TILE_W * PF_COLS);
    localparam logic [9:0] BRD_R0    = 10'(ORIGIN_ROW - BORDER);
    localparam logic [9:0] BRD_R1    = 10'(ORIGIN_ROW + TILE_H * PF_ROWS + BORDER);
    localparam logic [9:0] BRD_C0    = 10'(ORIGIN_COL - BORDER);
    localparam logic [9:0] BRD_C1    = 10'(ORIGIN_COL + TILE_W * PF_COLS + BORDER);
    localparam logic [9:0] VBL_ROW   = 10'(V_VISIBLE);
    localparam logic [4:0] SUBX_LAST = 5'(TILE_W - 1);
    localparam logic [4:0] SUBY_LAST = 5'(TILE_H - 1);
    localparam logic [3:0] N_COLS    = 4'(PF_COLS);
    localparam logic [4:0] N_ROWS    = 5'(PF_ROWS);

    localparam logic [23:0] RGB_BG     = 24'h202020;
    localparam logic [23:0] RGB_BORDER = 24'h146450;
`ifdef GRID_LINES_EN
    localparam logic [23:0] RGB_GRID   = 24'h101010;
`endif

    typedef enum logic {
        S_IDLE,
        S_PEND
    } swap_state_t;

    function automatic logic [23:0] palette(input logic [2:0] code);
        logic [23:0] c;
        case (code)
            3'd1:    c = 24'h00FDFF;
            3'd2:    c = 24'hFFFF00;
            3'd3:    c = 24'hFF00FF;
            3'd4:    c = 24'h0000FF;
            3'd5:    c = 24'hFF8000;
            3'd6:    c = 24'h00FF00;
            3'd7:    c = 24'hFF0000;
            default: c = 24'h000000;
        endcase
        return c;
    endfunction

    // Tile buffers: game logic only ever touches back_q; front_q is what gets displayed.
    logic [2:0] back_q  [PF_ROWS][PF_COLS];
    logic [2:0] front_q [PF_ROWS][PF_COLS];

    // Stage 1 registers
    logic [9:0] row_q, col_q;
    logic       hs1_q, vs1_q, blank1_q;
    logic [3:0] tx_q, tx_d;
    logic [4:0] ty_q, ty_d;
    logic [4:0] sub_x_q, sub_x_d;
    logic [4:0] sub_y_q, sub_y_d;

    // Stage 2 registers
    logic [23:0] rgb_q, rgb_d;
    logic        hs2_q, vs2_q, blank2_q;

    // Control
    swap_state_t state_q, state_d;
    logic        do_swap;
    logic        swap_done_q, wr_err_q;
    logic        vblank_entry, wr_ok;
    logic        in_field, in_border;
    logic [2:0]  tile_code;

    assign vblank_entry = (row_in == VBL_ROW) && (col_in == 10'd0);
    assign wr_ok        = (wr_x < N_COLS) && (wr_y < N_ROWS);

    // Tile position is tracked incrementally rather than divided out of row/col.
    // The counters free-run outside the field; only in-field values are ever used.
    always_comb begin
        tx_d    = tx_q;
        sub_x_d = sub_x_q;
        ty_d    = ty_q;
        sub_y_d = sub_y_q;
        if (col_in == FIELD_C0) begin
            tx_d    = '0;
            sub_x_d = '0;
        end else if (sub_x_q == SUBX_LAST) begin
            tx_d    = tx_q + 4'd1;
            sub_x_d = '0;
        end else begin
            sub_x_d = sub_x_q + 5'd1;
        end
        if (row_in == FIELD_R0) begin
            ty_d    = '0;
            sub_y_d = '0;
        end else if (col_in == 10'd0) begin
            if (sub_y_q == SUBY_LAST) begin
                ty_d    = ty_q + 5'd1;
                sub_y_d = '0;
            end else begin
                sub_y_d = sub_y_q + 5'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_q    <= '0;
            col_q    <= '0;
            hs1_q    <= 1'b0;
            vs1_q    <= 1'b0;
            blank1_q <= 1'b1;
            tx_q     <= '0;
            ty_q     <= '0;
            sub_x_q  <= '0;
            sub_y_q  <= '0;
        end else begin
            row_q    <= row_in;
            col_q    <= col_in;
            hs1_q    <= hs_in;
            vs1_q    <= vs_in;
            blank1_q <= blank_in;
            tx_q     <= tx_d;
            ty_q     <= ty_d;
            sub_x_q  <= sub_x_d;
            sub_y_q  <= sub_y_d;
        end
    end

    assign in_field  = (row_q >= FIELD_R0) && (row_q < FIELD_R1) &&
                       (col_q >= FIELD_C0) && (col_q < FIELD_C1);
    assign in_border = (row_q >= BRD_R0) && (row_q < BRD_R1) &&
                       (col_q >= BRD_C0) && (col_q < BRD_C1);

    // Colour priority: blank, field tile, border ring, background.
    always_comb begin
        tile_code = '0;
        if ((ty_q < N_ROWS) && (tx_q < N_COLS)) begin
            tile_code = front_q[ty_q][tx_q];
        end
        rgb_d = RGB_BG;
        if (blank1_q) begin
            rgb_d = '0;
        end else if (in_field) begin
            rgb_d = palette(tile_code);
`ifdef GRID_LINES_EN
            if ((sub_x_q == 5'd0) || (sub_y_q == 5'd0)) begin
                rgb_d = RGB_GRID;
            end
`endif
        end else if (in_border) begin
            rgb_d = RGB_BORDER;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rgb_q    <= '0;
            hs2_q    <= 1'b0;
            vs2_q    <= 1'b0;
            blank2_q <= 1'b1;
        end else begin
            rgb_q    <= rgb_d;
            hs2_q    <= hs1_q;
            vs2_q    <= vs1_q;
            blank2_q <= blank1_q;
        end
    end

    // Swaps do not queue: a request while pending is absorbed, and a request landing on
    // the vblank-entry cycle itself only arms the swap for the following frame.
    always_comb begin
        state_d = state_q;
        do_swap = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (swap_req) begin
                    state_d = S_PEND;
                end
            end
            S_PEND: begin
                if (vblank_entry) begin
                    state_d = S_IDLE;
                    do_swap = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            swap_done_q <= 1'b0;
            wr_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            swap_done_q <= do_swap;
            wr_err_q    <= wr_en && !wr_ok;
        end
    end

    // The copy samples back_q before this edge's write, so a coincident write
    // lands in the back buffer only and shows up after the next swap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < PF_ROWS; r++) begin
                for (int c = 0; c < PF_COLS; c++) begin
                    back_q[r][c]  <= '0;
                    front_q[r][c] <= '0;
                end
            end
        end else begin
            if (wr_en && wr_ok) begin
                back_q[wr_y][wr_x] <= wr_color;
            end
            if (do_swap) begin
                front_q <= back_q;
            end
        end
    end

    assign swap_pend = (state_q == S_PEND);
    assign swap_done = swap_done_q;
    assign wr_err    = wr_err_q;
    assign rgb_out   = rgb_q;
    assign hs_out    = hs2_q;
    assign vs_out    = vs2_q;
    assign blank_out = blank2_q;

endmodule

// File: tb/tb_svga_playfield_renderer.sv
// Scoreboard bench for svga_playfield_renderer: a compressed raster scan drives the DUT,
// a geometric reference model predicts every output, and a negedge monitor compares.
// Directed writes/swaps/reset are scheduled by (frame,row,col); later frames are random.
`timescale 1ns/1ps
module tb_svga_playfield_renderer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [9:0]  row_in = '0;
    logic [9:0]  col_in = '0;
    logic        hs_in = 1'b0;
    logic        vs_in = 1'b0;
    logic        blank_in = 1'b1;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_x = '0;
    logic [4:0]  wr_y = '0;
    logic [2:0]  wr_color = '0;
    logic        swap_req = 1'b0;
    logic        swap_pend, swap_done, wr_err;
    logic [23:0] rgb_out;
    logic        hs_out, vs_out, blank_out;

    svga_playfield_renderer dut (
        .clk(clk), .reset_n(reset_n),
        .row_in(row_in), .col_in(col_in),
        .hs_in(hs_in), .vs_in(vs_in), .blank_in(blank_in),
        .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color),
        .swap_req(swap_req), .swap_pend(swap_pend), .swap_done(swap_done), .wr_err(wr_err),
        .rgb_out(rgb_out), .hs_out(hs_out), .vs_out(vs_out), .blank_out(blank_out)
    );

    always #5 clk = ~clk;

    typedef struct { int due; int r; int c; logic [23:0] rgb; logic [2:0] sync; bit chk; } pix_t;
    typedef struct { int due; logic [2:0] st; } st_t;
    typedef struct { int frm; int r; int c; int kind; int x; int y; int col; } act_t;

    pix_t pix_q[$];
    st_t  st_q[$];
    act_t act_q[$];
    pix_t mp;
    st_t  ms;

    int  front_m [20][10];
    int  back_m  [20][10];
    bit  pend_m = 1'b0;
    bit  ctr_valid = 1'b0;
    bit  in_rst = 1'b1;
    bit  rnd_on = 1'b0;
    int  frame_no = 0;
    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    int  sample_rows [15] = '{10, 46, 48, 50, 51, 74, 75, 175, 199, 200, 300, 525, 549, 553, 554};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [23:0] pal_m(input int code);
        case (code)
            1: return 24'h00FDFF;
            2: return 24'hFFFF00;
            3: return 24'hFF00FF;
            4: return 24'h0000FF;
            5: return 24'hFF8000;
            6: return 24'h00FF00;
            7: return 24'hFF0000;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic bit field_px(input int r, input int c);
        return (r >= 50 && r < 550 && c >= 300 && c < 500);
    endfunction

    function automatic logic [23:0] exp_rgb(input int r, input int c, input bit bl);
        int ty, tx;
        if (bl) return 24'h000000;
        if (field_px(r, c)) begin
            ty = (r - 50) / 25;
            tx = (c - 300) / 20;
`ifdef GRID_LINES_EN
            if ((r - 50) % 25 == 0 || (c - 300) % 20 == 0) return 24'h101010;
`endif
            return pal_m(front_m[ty][tx]);
        end
        if (r >= 46 && r < 554 && c >= 296 && c < 504) return 24'h146450;
        return 24'h202020;
    endfunction

    function automatic bit is_sample(input int r);
        foreach (sample_rows[i]) if (sample_rows[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear();
        for (int y = 0; y < 20; y++)
            for (int x = 0; x < 10; x++) begin
                front_m[y][x] = 0;
                back_m[y][x]  = 0;
            end
        pend_m = 1'b0;
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        in_rst   = 1'b1;
        wr_en    = 1'b0;
        swap_req = 1'b0;
        pix_q.delete();
        st_q.delete();
        #1;
        chk("rst_rgb", 32'(rgb_out), 32'h0);
        chk("rst_sync", 32'({hs_out, vs_out, blank_out}), 32'd1);
        chk("rst_status", 32'({swap_pend, swap_done, wr_err}), 32'd0);
        model_clear();
        ctr_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        in_rst  = 1'b0;
    endtask

    task automatic add_act(input int f, input int r, input int c, input int k,
                           input int x, input int y, input int col);
        act_t a;
        a.frm = f; a.r = r; a.c = c; a.kind = k; a.x = x; a.y = y; a.col = col;
        act_q.push_back(a);
    endtask

    // One pixel clock of the raster: apply actions, drive inputs, advance the model.
    task automatic step(input int r, input int c);
        bit we, sreq, do_rst, bl, vbe, done, err;
        int x, y, col;
        logic hs, vs;
        act_t a;
        pix_t p;
        st_t  s;
        we = 0; sreq = 0; do_rst = 0; x = 0; y = 0; col = 0;
        while (act_q.size() > 0 && act_q[0].frm == frame_no && act_q[0].r == r && act_q[0].c == c) begin
            a = act_q.pop_front();
            case (a.kind)
                0: begin we = 1; x = a.x; y = a.y; col = a.col; end
                1: sreq = 1;
                default: do_rst = 1;
            endcase
        end
        if (rnd_on && !we && $urandom_range(31, 0) == 0) begin
            we = 1; x = $urandom_range(11, 0); y = $urandom_range(21, 0); col = $urandom_range(7, 0);
        end
        if (rnd_on && $urandom_range(1499, 0) == 0) sreq = 1;
        hs = 1'($urandom_range(1, 0));
        vs = (r >= 601 && r < 605);
        bl = (r >= 600) || (c >= 800) || ($urandom_range(15, 0) == 0);

        @(posedge clk);
        #1;
        if (do_rst) do_reset();
        row_in   = 10'(r);
        col_in   = 10'(c);
        hs_in    = hs;
        vs_in    = vs;
        blank_in = bl;
        wr_en    = we;
        wr_x     = 4'(x);
        wr_y     = 5'(y);
        wr_color = 3'(col);
        swap_req = sreq;

        if (r == 50) ctr_valid = 1'b1;
        vbe  = (r == 600 && c == 0);
        done = pend_m && vbe;
        if (done) front_m = back_m;
        if (pend_m && vbe) pend_m = 1'b0;
        else if (sreq) pend_m = 1'b1;
        err = 1'b0;
        if (we) begin
            if (x < 10 && y < 20) back_m[y][x] = col;
            else err = 1'b1;
        end

        p.due = cyc + 2; p.r = r; p.c = c;
        p.rgb = exp_rgb(r, c, bl);
        p.sync = {hs, vs, bl};
        p.chk = ctr_valid || bl || !field_px(r, c);
        pix_q.push_back(p);
        s.due = cyc + 1;
        s.st = {pend_m, done, err};
        st_q.push_back(s);
    endtask

    task automatic run_frame();
        int sr1, sr2;
        sr1 = $urandom_range(549, 50);
        sr2 = $urandom_range(549, 50);
        for (int r = 0; r < 620; r++) begin
            step(r, 0);
            step(r, 10);
            if (is_sample(r) || r == sr1 || r == sr2)
                for (int c = 294; c <= 506; c++) step(r, c);
            step(r, 850);
        end
        frame_no++;
    endtask

    always @(negedge clk) begin
        if (!in_rst) begin
            while (pix_q.size() > 0 && pix_q[0].due <= cyc) begin
                mp = pix_q.pop_front();
                if (mp.due != cyc) chk("pix_late", 32'(cyc), 32'(mp.due));
                chk($sformatf("sync(%0d,%0d)", mp.r, mp.c), 32'({hs_out, vs_out, blank_out}), 32'(mp.sync));
                if (mp.chk) chk($sformatf("rgb(%0d,%0d)", mp.r, mp.c), 32'(rgb_out), 32'(mp.rgb));
            end
            while (st_q.size() > 0 && st_q[0].due <= cyc) begin
                ms = st_q.pop_front();
                if (ms.due != cyc) chk("st_late", 32'(cyc), 32'(ms.due));
                chk($sformatf("pend_done_err@%0d", cyc), 32'({swap_pend, swap_done, wr_err}), 32'(ms.st));
            end
        end
    end

    initial begin
        // Frame 0: writes (one valid, two out of range, far corner) with no swap.
        add_act(0, 10, 10, 0, 3, 5, 2);
        add_act(0, 20, 10, 0, 10, 3, 1);
        add_act(0, 30, 10, 0, 2, 20, 4);
        add_act(0, 40, 10, 0, 9, 19, 5);
        // Frame 2: swap request, then a redundant one while pending.
        add_act(2, 100, 0, 1, 0, 0, 0);
        add_act(2, 200, 0, 1, 0, 0, 0);
        // Frame 3: another write, a swap, and a write on the vblank-entry edge.
        add_act(3, 20, 10, 0, 4, 5, 7);
        add_act(3, 300, 10, 1, 0, 0, 0);
        add_act(3, 600, 0, 0, 0, 0, 6);
        // Frame 4: swap request exactly at vblank entry while idle.
        add_act(4, 600, 0, 1, 0, 0, 0);
        // Frame 6: pending swap and a write wiped by a mid-line reset.
        add_act(6, 100, 0, 1, 0, 0, 0);
        add_act(6, 200, 10, 0, 1, 1, 3);
        add_act(6, 300, 400, 2, 0, 0, 0);

        #3;
        do_reset();
        for (int f = 0; f < 9; f++) begin
            rnd_on = (f >= 7);
            run_frame();
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
        #1;
        chk("drain", 32'(pix_q.size() + st_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
